// File: rtl/noc_local_packetizer.sv
// Network-interface packetizer: turns a (dest, len) command plus a payload word stream into
// header/body/tail flits for a router local receive port. One packet in flight at a time.
module noc_local_packetizer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned COORD_W    = 4,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned X_ID       = 0,
  parameter int unsigned Y_ID       = 0
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [COORD_W-1:0]    cmd_dest_x,
  input  logic [COORD_W-1:0]    cmd_dest_y,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  sender_valid,
  input  logic                  sender_ready,
  output logic [DATA_WIDTH-1:0] sender_flit,
  output logic                  sender_is_header,
  output logic                  sender_is_tail,
  output logic [7:0]            sent_num
);

  typedef enum logic [1:0] {StIdle, StHead, StBody} state_e;

  state_e                state_q, state_d;
  logic                  init_q;
  logic [DATA_WIDTH-1:0] flit_q;
  logic                  valid_q, is_header_q, is_tail_q;
  logic [LEN_W-1:0]      remaining_q;
  logic [7:0]            sent_num_q;
  logic [DATA_WIDTH-1:0] header;
  logic                  cmd_fire, data_fire, flit_fire, tail_fire;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign data_fire = data_valid && data_ready;
  assign flit_fire = valid_q && sender_ready;
  assign tail_fire = flit_fire && is_tail_q;

  always_comb begin
    header = '0;
    header[LEN_W-1:0]                     = cmd_len;
    header[LEN_W +: COORD_W]              = cmd_dest_x;
    header[LEN_W + COORD_W +: COORD_W]    = cmd_dest_y;
    header[LEN_W + 2*COORD_W +: COORD_W]  = COORD_W'(X_ID);
    header[LEN_W + 3*COORD_W +: COORD_W]  = COORD_W'(Y_ID);
  end

  // State register
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cmd_fire) state_d = StHead;
      StHead: if (flit_fire) state_d = is_tail_q ? StIdle : StBody;
      StBody: if (tail_fire) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; payload is only taken while the flit register can absorb it and words remain
  always_comb begin
    cmd_ready  = init_q && (state_q == StIdle);
    data_ready = (state_q == StBody) && (remaining_q != '0) && (!valid_q || sender_ready);
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      init_q      <= 1'b0;
      flit_q      <= '0;
      valid_q     <= 1'b0;
      is_header_q <= 1'b0;
      is_tail_q   <= 1'b0;
      remaining_q <= '0;
      sent_num_q  <= '0;
    end else begin
      init_q <= 1'b1;
      if (cmd_fire) begin
        flit_q      <= header;
        valid_q     <= 1'b1;
        is_header_q <= 1'b1;
        is_tail_q   <= (cmd_len == '0);
        remaining_q <= cmd_len;
      end else if (data_fire) begin
        flit_q      <= data;
        valid_q     <= 1'b1;
        is_header_q <= 1'b0;
        is_tail_q   <= (remaining_q == LEN_W'(1));
        remaining_q <= remaining_q - LEN_W'(1);
      end else if (flit_fire) begin
        valid_q     <= 1'b0;
        is_header_q <= 1'b0;
        is_tail_q   <= 1'b0;
      end
      if (tail_fire) begin
        sent_num_q <= sent_num_q + 8'd1;
      end
    end
  end

  assign sender_valid     = valid_q;
  assign sender_flit      = flit_q;
  assign sender_is_header = is_header_q;
  assign sender_is_tail   = is_tail_q;
  assign sent_num         = sent_num_q;

endmodule

// File: tb/tb_noc_local_packetizer.sv
// Directed self-checking bench for noc_local_packetizer (X_ID=0, Y_ID=0).
module tb_noc_local_packetizer;

  logic        noc_clk = 1'b0;
  logic        noc_rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_dest_x = '0;
  logic [3:0]  cmd_dest_y = '0;
  logic [7:0]  cmd_len = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [31:0] data = '0;
  logic        sender_valid;
  logic        sender_ready = 1'b1;
  logic [31:0] sender_flit;
  logic        sender_is_header;
  logic        sender_is_tail;
  logic [7:0]  sent_num;

  int n_checks = 0;
  int n_errors = 0;

  noc_local_packetizer #(
    .DATA_WIDTH(32), .COORD_W(4), .LEN_W(8), .X_ID(0), .Y_ID(0)
  ) dut (
    .noc_clk          (noc_clk),
    .noc_rst_n        (noc_rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_dest_x       (cmd_dest_x),
    .cmd_dest_y       (cmd_dest_y),
    .cmd_len          (cmd_len),
    .data_valid       (data_valid),
    .data_ready       (data_ready),
    .data             (data),
    .sender_valid     (sender_valid),
    .sender_ready     (sender_ready),
    .sender_flit      (sender_flit),
    .sender_is_header (sender_is_header),
    .sender_is_tail   (sender_is_tail),
    .sent_num         (sent_num)
  );

  always #5 noc_clk = ~noc_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] cyc = '0;
  always @(posedge noc_clk) cyc <= cyc + 32'd1;

  // Payload source: pops on handshake, optionally presents a word only every other cycle
  logic [31:0] pay_q[$];
  bit          bubble_en = 1'b0;
  bit          tog = 1'b0;
  always @(posedge noc_clk) begin
    if (data_valid && data_ready && pay_q.size() > 0) pay_q.delete(0);
    #1;
    tog = ~tog;
    data_valid = (pay_q.size() > 0) && (!bubble_en || tog);
    data = (pay_q.size() > 0) ? pay_q[0] : 32'd0;
  end

  typedef struct packed {
    logic        h;
    logic        t;
    logic [31:0] f;
    logic [31:0] c;
  } mon_t;
  mon_t mon_q[$];
  always @(posedge noc_clk) begin
    if (noc_rst_n && sender_valid && sender_ready)
      mon_q.push_back({sender_is_header, sender_is_tail, sender_flit, cyc});
  end

  // Held flit must not change across a stalled edge
  logic        stall_prev = 1'b0;
  logic [34:0] snap = '0;
  always @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", 64'({sender_valid, sender_is_header, sender_is_tail, sender_flit}),
              64'(snap));
      stall_prev <= sender_valid && !sender_ready;
      snap <= {sender_valid, sender_is_header, sender_is_tail, sender_flit};
    end
  end

  task automatic step();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] len);
    int n;
    cmd_valid = 1'b1;
    cmd_dest_x = dx;
    cmd_dest_y = dy;
    cmd_len = len;
    n = 0;
    do begin
      @(posedge noc_clk);
      n++;
    end while (!cmd_ready && n < 200);
    check("cmd_accept", 64'(cmd_ready), 64'(1));
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_sent(input string tag, input logic [7:0] target);
    int n;
    n = 0;
    while (sent_num != target && n < 500) begin
      @(negedge noc_clk);
      n++;
    end
    check(tag, 64'(sent_num), 64'(target));
  endtask

  task automatic wait_flit(input string tag, input logic [31:0] f);
    int n;
    n = 0;
    while (!(sender_valid && sender_flit == f) && n < 100) begin
      @(negedge noc_clk);
      n++;
    end
    check(tag, 64'(sender_flit), 64'(f));
  endtask

  task automatic check_flit(input string tag, input int idx, input logic h, input logic t,
                            input logic [31:0] f);
    logic [33:0] got;
    got = 'x;
    if (idx < mon_q.size()) got = {mon_q[idx].h, mon_q[idx].t, mon_q[idx].f};
    check(tag, 64'(got), 64'({h, t, f}));
  endtask

  task automatic check_gap(input string tag, input int idx, input logic [31:0] exp);
    logic [31:0] got;
    got = 'x;
    if (idx < mon_q.size()) got = mon_q[idx].c - mon_q[idx-1].c;
    check(tag, 64'(got), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int bad;
    int n;

    // Reset values
    repeat (2) @(posedge noc_clk);
    @(negedge noc_clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_data_ready", 64'(data_ready), 64'(0));
    check("rst_valid", 64'(sender_valid), 64'(0));
    check("rst_flit", 64'(sender_flit), 64'(0));
    check("rst_hdr_tail", 64'({sender_is_header, sender_is_tail}), 64'(0));
    check("rst_sent", 64'(sent_num), 64'(0));
    noc_rst_n = 1'b1;
    step();
    step();
    check("idle_cmd_ready", 64'(cmd_ready), 64'(1));

    // Basic len=3 packet to (1,1)
    mon_q.delete();
    pay_q.push_back(32'hA1); pay_q.push_back(32'hA2); pay_q.push_back(32'hA3);
    issue_cmd(4'd1, 4'd1, 8'd3);
    wait_sent("t1_sent", 8'd1);
    step();
    check("t1_count", 64'(mon_q.size()), 64'(4));
    check_flit("t1_hdr", 0, 1'b1, 1'b0, 32'h0000_1103);
    check_flit("t1_b1", 1, 1'b0, 1'b0, 32'hA1);
    check_flit("t1_b2", 2, 1'b0, 1'b0, 32'hA2);
    check_flit("t1_b3", 3, 1'b0, 1'b1, 32'hA3);
    check_gap("t1_b2b_a", 2, 32'd1);
    check_gap("t1_b2b_b", 3, 32'd1);

    // Header-only packet to (1,0)
    mon_q.delete();
    issue_cmd(4'd1, 4'd0, 8'd0);
    check("t2_busy", 64'(cmd_ready), 64'(0));
    wait_sent("t2_sent", 8'd2);
    check("t2_ready_next", 64'(cmd_ready), 64'(1));
    step();
    check("t2_count", 64'(mon_q.size()), 64'(1));
    check_flit("t2_hdr", 0, 1'b1, 1'b1, 32'h0000_0100);

    // Backpressure on the 2nd body flit
    mon_q.delete();
    pay_q.push_back(32'hB1); pay_q.push_back(32'hB2); pay_q.push_back(32'hB3);
    issue_cmd(4'd2, 4'd1, 8'd3);
    wait_flit("t3_b2_seen", 32'hB2);
    sender_ready = 1'b0;
    repeat (4) begin
      @(negedge noc_clk);
      check("t3_stall_flit", 64'({sender_valid, sender_flit}), 64'({1'b1, 32'hB2}));
      check("t3_stall_tail", 64'(sender_is_tail), 64'(0));
      check("t3_stall_dready", 64'(data_ready), 64'(0));
    end
    sender_ready = 1'b1;
    wait_sent("t3_sent", 8'd3);
    step();
    check("t3_count", 64'(mon_q.size()), 64'(4));
    check_flit("t3_hdr", 0, 1'b1, 1'b0, 32'h0000_1203);
    check_flit("t3_b1", 1, 1'b0, 1'b0, 32'hB1);
    check_flit("t3_b2", 2, 1'b0, 1'b0, 32'hB2);
    check_flit("t3_b3", 3, 1'b0, 1'b1, 32'hB3);

    // Payload bubbles, len=4 to (0,2)
    mon_q.delete();
    bubble_en = 1'b1;
    pay_q.push_back(32'hC1); pay_q.push_back(32'hC2);
    pay_q.push_back(32'hC3); pay_q.push_back(32'hC4);
    issue_cmd(4'd0, 4'd2, 8'd4);
    wait_sent("t4_sent", 8'd4);
    bubble_en = 1'b0;
    step();
    check("t4_count", 64'(mon_q.size()), 64'(5));
    check_flit("t4_hdr", 0, 1'b1, 1'b0, 32'h0000_2004);
    check_flit("t4_b1", 1, 1'b0, 1'b0, 32'hC1);
    check_flit("t4_b2", 2, 1'b0, 1'b0, 32'hC2);
    check_flit("t4_b3", 3, 1'b0, 1'b0, 32'hC3);
    check_flit("t4_b4", 4, 1'b0, 1'b1, 32'hC4);
    for (int i = 2; i <= 4; i++) check_gap("t4_bubble_gap", i, 32'd2);

    // Command held high through an active packet
    mon_q.delete();
    pay_q.push_back(32'hD1); pay_q.push_back(32'hD2); pay_q.push_back(32'hE1);
    issue_cmd(4'd2, 4'd3, 8'd2);
    cmd_valid = 1'b1;
    cmd_dest_x = 4'd3;
    cmd_dest_y = 4'd2;
    cmd_len = 8'd1;
    bad = 0;
    n = 0;
    while (sent_num != 8'd5 && n < 100) begin
      @(negedge noc_clk);
      if (sent_num != 8'd5 && cmd_ready) bad++;
      n++;
    end
    check("t5_held_off", 64'(bad), 64'(0));
    check("t5_ready_after_tail", 64'(cmd_ready), 64'(1));
    @(posedge noc_clk);
    #1;
    cmd_valid = 1'b0;
    wait_sent("t5_sent", 8'd6);
    step();
    check("t5_count", 64'(mon_q.size()), 64'(5));
    check_flit("t5_hdr_a", 0, 1'b1, 1'b0, 32'h0000_3202);
    check_flit("t5_d1", 1, 1'b0, 1'b0, 32'hD1);
    check_flit("t5_d2", 2, 1'b0, 1'b1, 32'hD2);
    check_flit("t5_hdr_b", 3, 1'b1, 1'b0, 32'h0000_2301);
    check_flit("t5_e1", 4, 1'b0, 1'b1, 32'hE1);
    check_gap("t5_hdr_gap", 3, 32'd2);

    // Reset mid-packet
    mon_q.delete();
    for (int i = 1; i <= 5; i++) pay_q.push_back(32'hF0 + 32'(i));
    issue_cmd(4'd1, 4'd1, 8'd5);
    wait_flit("t6_f1_seen", 32'hF1);
    #2;
    noc_rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(sender_valid), 64'(0));
    check("t6_rst_flit", 64'(sender_flit), 64'(0));
    check("t6_rst_hdr_tail", 64'({sender_is_header, sender_is_tail}), 64'(0));
    check("t6_rst_sent", 64'(sent_num), 64'(0));
    check("t6_rst_readies", 64'({cmd_ready, data_ready}), 64'(0));
    pay_q.delete();
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    step();
    step();
    mon_q.delete();
    pay_q.push_back(32'h6001);
    issue_cmd(4'd1, 4'd2, 8'd1);
    wait_sent("t6_sent", 8'd1);
    step();
    check("t6_count", 64'(mon_q.size()), 64'(2));
    check_flit("t6_hdr", 0, 1'b1, 1'b0, 32'h0000_2101);
    check_flit("t6_g1", 1, 1'b0, 1'b1, 32'h6001);

    // sent_num wraps after 256 packets
    for (int i = 0; i < 254; i++) issue_cmd(4'd0, 4'd0, 8'd0);
    wait_sent("wrap_255", 8'd255);
    issue_cmd(4'd0, 4'd0, 8'd0);
    wait_sent("wrap_0", 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
